nx_mimosa_v40_smooth_tx: RTL and testbench

NX_MIMOSA_V40_SMOOTH_TX -- requirements
Module: nx_mimosa_v40_smooth_tx

---
 rtl/nx_mimosa_v40_smooth_tx_if.sv | 17 +
 rtl/nx_mimosa_v40_smooth_tx.sv | 166 ++++++++++++++++
 tb/tb_nx_mimosa_v40_smooth_tx.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nx_mimosa_v40_smooth_tx_if.sv
// Fixed-point type shared by the smoother output path, plus the outbound word stream
// (valid/ready handshake, last-word marker) used by the frame transmitter.
package nx_mimosa_v40_pkg;
  typedef logic [31:0] fp_t;
  localparam int STATE_DIM = 6;
endpackage

interface nx_mimosa_v40_smooth_tx_if;
  import nx_mimosa_v40_pkg::*;
  fp_t  tdata;
  logic tvalid;
  logic tready;
  logic tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/nx_mimosa_v40_smooth_tx.sv
// Buffers smoothed states in a small FIFO and streams each one out as a framed packet:
// header, state words, quality word, XOR checksum (tlast on the checksum word).
module nx_mimosa_v40_smooth_tx
  import nx_mimosa_v40_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MODEL_IDX  = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  fp_t [STATE_DIM-1:0]       x_smooth,
  input  fp_t                       quality,
  input  logic                      smooth_valid,
  input  logic                      cfg_enable,
  input  logic [7:0]                cfg_track_id,
  nx_mimosa_v40_smooth_tx_if.master m,
  output logic [15:0]               drop_count,
  output logic                      busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = (STATE_DIM > 1) ? $clog2(STATE_DIM) : 1;
  localparam logic [3:0] MIDX = 4'(MODEL_IDX);
  localparam logic [3:0] SDIM = 4'(STATE_DIM);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HDR, S_STATE, S_QUAL, S_CSUM} state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  fp_t [STATE_DIM-1:0] st_mem_q  [FIFO_DEPTH];
  fp_t                 qual_mem_q[FIFO_DEPTH];
  logic [7:0]          tid_mem_q [FIFO_DEPTH];
  logic [7:0]          seq_mem_q [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    seq_q;
  logic [15:0]   drop_q;
  state_e        state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;

  fp_t [STATE_DIM-1:0] sh_st_q;
  fp_t                 sh_qual_q;
  logic [7:0]          sh_tid_q, sh_seq_q;
  fp_t                 csum_q;

  logic full, empty, strobe_en, wr_en, drop, pop, hs;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign strobe_en = smooth_valid && cfg_enable;
  // A pop in the same cycle frees a slot, so a strobe against a full FIFO is still taken.
  assign wr_en     = strobe_en && (!full || pop);
  assign drop      = strobe_en && full && !pop;
  assign hs        = m.tvalid && m.tready;

  assign drop_count = drop_q;
  assign busy       = !empty || (state_q != S_IDLE);

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
    end else begin
      count_q <= count_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        seq_q    <= seq_q + 8'd1;
      end
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (drop) drop_q   <= sat_inc(drop_q);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      st_mem_q[wr_ptr_q]   <= x_smooth;
      qual_mem_q[wr_ptr_q] <= quality;
      tid_mem_q[wr_ptr_q]  <= cfg_track_id;
      seq_mem_q[wr_ptr_q]  <= seq_q;
    end
    if (pop) begin
      sh_st_q   <= st_mem_q[rd_ptr_q];
      sh_qual_q <= qual_mem_q[rd_ptr_q];
      sh_tid_q  <= tid_mem_q[rd_ptr_q];
      sh_seq_q  <= seq_mem_q[rd_ptr_q];
      csum_q    <= '0;
    end else if (hs && (state_q != S_CSUM)) begin
      csum_q <= csum_q ^ m.tdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_LOAD;
      S_LOAD:  state_d = S_HDR;
      S_HDR:   if (hs) begin
        state_d = S_STATE;
        wcnt_d  = '0;
      end
      S_STATE: if (hs) begin
        if (wcnt_q == WW'(STATE_DIM - 1)) state_d = S_QUAL;
        else                              wcnt_d  = wcnt_q + WW'(1);
      end
      S_QUAL:  if (hs) state_d = S_CSUM;
      S_CSUM:  if (hs) state_d = empty ? S_IDLE : S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m.tvalid = 1'b0;
    m.tlast  = 1'b0;
    m.tdata  = '0;
    pop      = 1'b0;
    case (state_q)
      S_LOAD:  pop = 1'b1;
      S_HDR: begin
        m.tvalid = 1'b1;
        m.tdata  = {8'hA5, sh_tid_q, MIDX, SDIM, sh_seq_q};
      end
      S_STATE: begin
        m.tvalid = 1'b1;
        m.tdata  = sh_st_q[wcnt_q];
      end
      S_QUAL: begin
        m.tvalid = 1'b1;
        m.tdata  = sh_qual_q;
      end
      S_CSUM: begin
        m.tvalid = 1'b1;
        m.tlast  = 1'b1;
        m.tdata  = csum_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nx_mimosa_v40_smooth_tx.sv
// Scoreboard bench for the smoothed-state frame transmitter.
module tb_nx_mimosa_v40_smooth_tx;
  import nx_mimosa_v40_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  fp_t [STATE_DIM-1:0] x_smooth = '0;
  fp_t                 quality = '0;
  logic                smooth_valid = 1'b0;
  logic                cfg_enable = 1'b0;
  logic [7:0]          cfg_track_id = '0;
  logic [15:0]         drop_count;
  logic                busy;

  nx_mimosa_v40_smooth_tx_if m_if ();

  nx_mimosa_v40_smooth_tx #(.FIFO_DEPTH(4), .MODEL_IDX(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .x_smooth     (x_smooth),
    .quality      (quality),
    .smooth_valid (smooth_valid),
    .cfg_enable   (cfg_enable),
    .cfg_track_id (cfg_track_id),
    .m            (m_if),
    .drop_count   (drop_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fails  = 0;
  logic [32:0] exp_q[$];
  int         gap_q[$];
  logic [7:0] model_seq = 0;
  int         hs_cnt = 0;
  bit         rnd_on = 0;

  // Monitor: scoreboard pop on each handshake, hold-stability, inter-frame gaps.
  bit          hold_pend = 0;
  logic [31:0] hold_data;
  logic        hold_last;
  bit          gap_on = 0;
  int          gap_len = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 0;
      gap_on    = 0;
    end else begin
      if (hold_pend) begin
        n_checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== hold_data || m_if.tlast !== hold_last) begin
          n_fails++;
          $display("FAIL hold_stable: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                   m_if.tvalid, m_if.tdata, m_if.tlast, hold_data, hold_last);
        end
      end
      if (gap_on) begin
        if (m_if.tvalid) begin
          gap_q.push_back(gap_len);
          gap_on = 0;
        end else gap_len++;
      end
      if (m_if.tvalid && m_if.tready) begin
        logic [32:0] e;
        hs_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("FAIL unexpected_word: got d=%h l=%b, required no word", m_if.tdata, m_if.tlast);
        end else begin
          e = exp_q.pop_front();
          if ({m_if.tlast, m_if.tdata} !== e) begin
            n_fails++;
            $display("FAIL stream_word: got l=%b d=%h, required l=%b d=%h",
                     m_if.tlast, m_if.tdata, e[32], e[31:0]);
          end
        end
        if (m_if.tlast) begin
          gap_on  = 1;
          gap_len = 0;
        end
      end
      hold_pend = m_if.tvalid && !m_if.tready;
      hold_data = m_if.tdata;
      hold_last = m_if.tlast;
    end
  end

  function automatic void push_frame(input logic [7:0] tid, input logic [7:0] sq,
                                     input fp_t [STATE_DIM-1:0] st, input fp_t ql);
    logic [31:0] cs;
    logic [31:0] hdr;
    hdr = {8'hA5, tid, 4'd0, 4'd6, sq};
    cs  = hdr;
    exp_q.push_back({1'b0, hdr});
    for (int i = 0; i < STATE_DIM; i++) begin
      exp_q.push_back({1'b0, st[i]});
      cs = cs ^ st[i];
    end
    exp_q.push_back({1'b0, ql});
    cs = cs ^ ql;
    exp_q.push_back({1'b1, cs});
  endfunction

  // Called at posedge+1; drives a one-cycle strobe and records the frame it should produce.
  task automatic do_strobe(input logic en, input logic [7:0] tid, input bit expect_cap);
    for (int i = 0; i < STATE_DIM; i++) x_smooth[i] = $urandom;
    quality      = $urandom;
    cfg_track_id = tid;
    cfg_enable   = en;
    smooth_valid = 1'b1;
    if (expect_cap) begin
      push_frame(tid, model_seq, x_smooth, quality);
      model_seq++;
    end
    @(posedge clk); #1;
    smooth_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    smooth_valid = 1'b0;
    exp_q.delete();
    gap_q.delete();
    model_seq = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !m_if.tvalid && !busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    m_if.tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 5;
    if (m_if.tvalid !== 1'b0) begin n_fails++; $display("FAIL rst_tvalid: got %b, required 0", m_if.tvalid); end
    if (m_if.tlast !== 1'b0) begin n_fails++; $display("FAIL rst_tlast: got %b, required 0", m_if.tlast); end
    if (m_if.tdata !== 32'h0) begin n_fails++; $display("FAIL rst_tdata: got %h, required 0", m_if.tdata); end
    if (busy !== 1'b0) begin n_fails++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (drop_count !== 16'h0) begin n_fails++; $display("FAIL rst_drop: got %h, required 0", drop_count); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    apply_reset();
    m_if.tready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < STATE_DIM; i++) x_smooth[i] = 32'h1000_0000 + i;
    quality = 32'hCAFE_0001;
    cfg_track_id = 8'h12;
    cfg_enable = 1'b1;
    smooth_valid = 1'b1;
    push_frame(8'h12, model_seq, x_smooth, quality);
    model_seq++;
    @(posedge clk); #1;
    smooth_valid = 1'b0;
    n_checks++;
    if (m_if.tvalid !== 1'b0) begin n_fails++; $display("FAIL lat_n0: got tvalid %b, required 0", m_if.tvalid); end
    @(posedge clk); #1;
    n_checks++;
    if (m_if.tvalid !== 1'b0) begin n_fails++; $display("FAIL lat_n1: got tvalid %b, required 0", m_if.tvalid); end
    @(posedge clk); #1;
    n_checks += 2;
    if (m_if.tvalid !== 1'b1) begin n_fails++; $display("FAIL lat_n2: got tvalid %b, required 1", m_if.tvalid); end
    if (m_if.tdata !== 32'hA512_0600) begin n_fails++; $display("FAIL hdr_literal: got %h, required a5120600", m_if.tdata); end
    wait_drain(100, ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL single_drain: got %0d words left, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    apply_reset();
    m_if.tready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) do_strobe(1'b1, 8'h34, 1'b1);
    wait_drain(200, ok);
    n_checks += 2;
    if (!ok) begin n_fails++; $display("FAIL b2b_drain: got %0d words left, required 0", exp_q.size()); end
    if (gap_q.size() != 2) begin n_fails++; $display("FAIL b2b_gap_count: got %0d, required 2", gap_q.size()); end
    while (gap_q.size() > 0) begin
      int g;
      g = gap_q.pop_front();
      n_checks++;
      if (g != 1) begin n_fails++; $display("FAIL b2b_gap: got %0d idle cycles, required 1", g); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    apply_reset();
    m_if.tready = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) do_strobe(1'b1, 8'h56, k < 5);
    repeat (3) @(posedge clk);
    #1;
    n_checks += 3;
    if (drop_count !== 16'd1) begin n_fails++; $display("FAIL bp_drop: got %0d, required 1", drop_count); end
    if (m_if.tvalid !== 1'b1) begin n_fails++; $display("FAIL bp_tvalid: got %b, required 1", m_if.tvalid); end
    if (m_if.tdata !== 32'hA556_0600) begin n_fails++; $display("FAIL bp_hdr: got %h, required a5560600", m_if.tdata); end
    m_if.tready = 1'b1;
    wait_drain(300, ok);
    n_checks += 2;
    if (!ok) begin n_fails++; $display("FAIL bp_drain: got %0d words left, required 0", exp_q.size()); end
    if (drop_count !== 16'd1) begin n_fails++; $display("FAIL bp_drop_after: got %0d, required 1", drop_count); end
  endtask

  task automatic test_random_ready();
    bit ok;
    apply_reset();
    rnd_on = 1;
    fork
      while (rnd_on) begin
        m_if.tready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    join_none
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      do_strobe(1'b1, 8'(8'h70 + k), 1'b1);
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #0;
    end
    wait_drain(2000, ok);
    rnd_on = 0;
    @(posedge clk); #1;
    m_if.tready = 1'b1;
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL rnd_drain: got %0d words left, required 0", exp_q.size()); end
  endtask

  task automatic test_enable();
    bit ok;
    int t;
    apply_reset();
    m_if.tready = 1'b1;
    @(posedge clk); #1;
    do_strobe(1'b0, 8'h9A, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    n_checks += 2;
    if (busy !== 1'b0) begin n_fails++; $display("FAIL en_off_busy: got %b, required 0", busy); end
    if (drop_count !== 16'd0) begin n_fails++; $display("FAIL en_off_drop: got %0d, required 0", drop_count); end
    do_strobe(1'b1, 8'h9B, 1'b1);
    t = 0;
    while (!m_if.tvalid && t < 20) begin @(posedge clk); #1; t++; end
    n_checks++;
    if (!m_if.tvalid) begin n_fails++; $display("FAIL en_start: got tvalid 0, required 1"); end
    repeat (2) @(posedge clk);
    #1;
    do_strobe(1'b0, 8'h9C, 1'b0);
    wait_drain(100, ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL en_mid_drain: got %0d words left, required 0", exp_q.size()); end
    do_strobe(1'b1, 8'h9D, 1'b1);
    wait_drain(100, ok);
    n_checks += 2;
    if (!ok) begin n_fails++; $display("FAIL en_seq_drain: got %0d words left, required 0", exp_q.size()); end
    if (drop_count !== 16'd0) begin n_fails++; $display("FAIL en_drop: got %0d, required 0", drop_count); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int base;
    int t;
    apply_reset();
    m_if.tready = 1'b1;
    @(posedge clk); #1;
    base = hs_cnt;
    do_strobe(1'b1, 8'hE1, 1'b1);
    t = 0;
    while ((hs_cnt - base) < 3 && t < 50) begin @(posedge clk); #1; t++; end
    n_checks++;
    if ((hs_cnt - base) < 3) begin n_fails++; $display("FAIL mid_reach_word4: got %0d words, required 3", hs_cnt - base); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (m_if.tvalid !== 1'b0) begin n_fails++; $display("FAIL mid_async_tvalid: got %b, required 0", m_if.tvalid); end
    if (busy !== 1'b0) begin n_fails++; $display("FAIL mid_async_busy: got %b, required 0", busy); end
    if (m_if.tdata !== 32'h0) begin n_fails++; $display("FAIL mid_async_tdata: got %h, required 0", m_if.tdata); end
    exp_q.delete();
    model_seq = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (m_if.tvalid !== 1'b0) begin n_fails++; $display("FAIL mid_no_resume: got tvalid %b, required 0", m_if.tvalid); end
    do_strobe(1'b1, 8'hE2, 1'b1);
    wait_drain(100, ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL mid_after_drain: got %0d words left, required 0", exp_q.size()); end
  endtask

  initial begin
    m_if.tready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random_ready();
    test_enable();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
